// File: rtl/pattern_frame_source_pkg.sv
// pattern_pkg: shared types for pattern_frame_source.
//   mode_t  - pixel source selected at frame start
//   state_t - frame sequencer states
//   bar_rgb - colour-bar table as {R,G,B} channel on/off masks; the top
//             widens each bit to the full channel width
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROM   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int NUM_BARS = 8;

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/pattern_frame_source_if.sv
// Avalon-ST video stream (readyLatency 0).
//   data, startofpacket, endofpacket, valid : source -> sink
//   ready                                   : sink -> source
interface pattern_frame_source_if #(
  parameter int PIX_W = 12
) ();

  logic [PIX_W-1:0] data;
  logic             startofpacket;
  logic             endofpacket;
  logic             valid;
  logic             ready;

  modport master (output data, output startofpacket, output endofpacket,
                  output valid, input ready);
  modport slave  (input data, input startofpacket, input endofpacket,
                  input valid, output ready);

endinterface

// File: rtl/pattern_frame_source_frame_coord_counter.sv
// frame_coord_counter: raster position of the pixel currently on the bus.
//   clk, reset       - clock, asynchronous active-high reset
//   clear            - force position to (0,0)
//   advance          - step to the next raster pixel (wraps after the last)
//   x, y, idx        - current column, line and linear index
//   last             - current pixel is (WIDTH-1,HEIGHT-1)
//   nxt_x/y/idx/last - the same values for the pixel after an advance
module frame_coord_counter #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] idx,
  output logic              last,
  output logic [X_W-1:0]    nxt_x,
  output logic [Y_W-1:0]    nxt_y,
  output logic [ADDR_W-1:0] nxt_idx,
  output logic              nxt_last
);

  logic [X_W-1:0]    x_r;
  logic [Y_W-1:0]    y_r;
  logic [ADDR_W-1:0] idx_r;
  logic              x_last_s;
  logic              y_last_s;

  assign x_last_s = (x_r == X_W'(WIDTH - 1));
  assign y_last_s = (y_r == Y_W'(HEIGHT - 1));
  assign last     = x_last_s && y_last_s;
  assign nxt_last = (nxt_x == X_W'(WIDTH - 1)) && (nxt_y == Y_W'(HEIGHT - 1));

  assign x   = x_r;
  assign y   = y_r;
  assign idx = idx_r;

  // Successor position: end of frame wraps to (0,0), end of line to next y.
  always_comb begin
    nxt_x   = x_r + X_W'(1);
    nxt_y   = y_r;
    nxt_idx = idx_r + ADDR_W'(1);
    if (last) begin
      nxt_x   = '0;
      nxt_y   = '0;
      nxt_idx = '0;
    end else if (x_last_s) begin
      nxt_x = '0;
      nxt_y = y_r + Y_W'(1);
    end else begin
      nxt_y = y_r;
    end
  end

  // Position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r   <= '0;
      y_r   <= '0;
      idx_r <= '0;
    end else if (clear) begin
      x_r   <= '0;
      y_r   <= '0;
      idx_r <= '0;
    end else if (advance) begin
      x_r   <= nxt_x;
      y_r   <= nxt_y;
      idx_r <= nxt_idx;
    end else begin
      x_r   <= x_r;
      y_r   <= y_r;
      idx_r <= idx_r;
    end
  end

endmodule

// File: rtl/pattern_frame_source.sv
// pattern_frame_source: test-pattern / ROM-image Avalon-ST video source.
//   clk, reset   - clock, asynchronous active-high reset
//   enable       - level; start or keep streaming frames
//   mode         - 0 ROM, 1 bars, 2 ramp, 3 checker (taken at frame start)
//   rom_addr     - address to a synchronous ROM with 1-cycle read latency
//   rom_data     - ROM read data
//   st           - video stream (data, sop, eop, valid out; ready in)
//   frame_count  - completed frames, wraps
//   busy         - sequencer is not IDLE
module pattern_frame_source
  import pattern_pkg::*;
#(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIX_W       = 12,
  parameter int GAP_CYCLES  = 16,
  parameter int CHECK_SHIFT = 3,
  parameter int GRAD_SHIFT  = 4,
  parameter int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [PIX_W-1:0]       rom_data,
  pattern_frame_source_if.master st,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam int CH_W     = PIX_W / 3;
  localparam int X_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_W      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TOTAL    = WIDTH * HEIGHT;
  localparam int BAR_W    = WIDTH / NUM_BARS;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t             state_r;
  mode_t              mode_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               valid_r;
  logic               sop_r;
  logic               eop_r;
  logic [PIX_W-1:0]   pattern_r;
  logic [2:0]         bar_idx_r;
  logic [X_W-1:0]     bar_cnt_r;
  logic [15:0]        frame_count_r;
  logic               busy_r;

  logic               transfer_s;
  logic               advance_s;
  logic               clear_s;
  logic [X_W-1:0]     x_s;
  logic [Y_W-1:0]     y_s;
  logic [ADDR_W-1:0]  idx_s;
  logic               last_s;
  logic [X_W-1:0]     nxt_x_s;
  logic [Y_W-1:0]     nxt_y_s;
  logic [ADDR_W-1:0]  nxt_idx_s;
  logic               nxt_last_s;
  logic [X_W-1:0]     tgt_x_s;
  logic [Y_W-1:0]     tgt_y_s;
  mode_t              mode_sel_s;
  logic [2:0]         nb_idx_s;
  logic [X_W-1:0]     nb_cnt_s;
  logic [CH_W-1:0]    ramp_ch_s;
  logic               chk_bit_s;
  logic [PIX_W-1:0]   pattern_nxt_s;

  function automatic logic [PIX_W-1:0] expand_rgb(input logic [2:0] rgb);
    return {{CH_W{rgb[2]}}, {CH_W{rgb[1]}}, {CH_W{rgb[0]}}};
  endfunction

  assign transfer_s = valid_r && st.ready;
  assign advance_s  = (state_r == STREAM) && transfer_s;
  assign clear_s    = (state_r == PREFETCH);

  frame_coord_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_coord (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .advance  (advance_s),
    .x        (x_s),
    .y        (y_s),
    .idx      (idx_s),
    .last     (last_s),
    .nxt_x    (nxt_x_s),
    .nxt_y    (nxt_y_s),
    .nxt_idx  (nxt_idx_s),
    .nxt_last (nxt_last_s)
  );

  // ROM address: the pixel that will be on the bus next cycle, so the
  // 1-cycle ROM latency lines rom_data up with the presented pixel.
  always_comb begin
    if (state_r == STREAM) begin
      if (transfer_s) begin
        rom_addr = nxt_idx_s;
      end else begin
        rom_addr = idx_s;
      end
    end else begin
      rom_addr = '0;
    end
  end

  // Coordinates and mode of the pixel the pattern registers load next.
  always_comb begin
    if (state_r == STREAM) begin
      tgt_x_s    = nxt_x_s;
      tgt_y_s    = nxt_y_s;
      mode_sel_s = mode_r;
    end else begin
      tgt_x_s    = '0;
      tgt_y_s    = '0;
      mode_sel_s = mode_t'(mode);
    end
  end

  // Bar tracker: last bar absorbs the WIDTH%8 remainder pixels.
  always_comb begin
    if (tgt_x_s == '0) begin
      nb_idx_s = 3'd0;
      nb_cnt_s = '0;
    end else if ((bar_cnt_r == X_W'(BAR_W - 1)) && (bar_idx_r != 3'd7)) begin
      nb_idx_s = bar_idx_r + 3'd1;
      nb_cnt_s = '0;
    end else begin
      nb_idx_s = bar_idx_r;
      nb_cnt_s = bar_cnt_r + X_W'(1);
    end
  end

  assign ramp_ch_s = CH_W'(tgt_x_s >> GRAD_SHIFT);
  assign chk_bit_s = 1'(tgt_x_s >> CHECK_SHIFT) ^ 1'(tgt_y_s >> CHECK_SHIFT);

  // Pattern value for the next presented pixel.
  always_comb begin
    case (mode_sel_s)
      MODE_BARS:  pattern_nxt_s = expand_rgb(bar_rgb(nb_idx_s));
      MODE_RAMP:  pattern_nxt_s = {3{ramp_ch_s}};
      MODE_CHECK: pattern_nxt_s = chk_bit_s ? expand_rgb(3'b000) : expand_rgb(3'b111);
      MODE_ROM:   pattern_nxt_s = '0;
      default:    pattern_nxt_s = '0;
    endcase
  end

  // Frame sequencer with registered stream flags, pattern and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      mode_r        <= MODE_ROM;
      gap_cnt_r     <= '0;
      valid_r       <= 1'b0;
      sop_r         <= 1'b0;
      eop_r         <= 1'b0;
      pattern_r     <= '0;
      bar_idx_r     <= 3'd0;
      bar_cnt_r     <= '0;
      frame_count_r <= 16'd0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= PREFETCH;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        PREFETCH: begin
          mode_r    <= mode_t'(mode);
          state_r   <= STREAM;
          valid_r   <= 1'b1;
          sop_r     <= 1'b1;
          eop_r     <= (TOTAL == 1);
          pattern_r <= pattern_nxt_s;
          bar_idx_r <= nb_idx_s;
          bar_cnt_r <= nb_cnt_s;
        end
        STREAM: begin
          // enable is deliberately ignored here: a frame always completes.
          if (transfer_s) begin
            if (last_s) begin
              state_r       <= GAP;
              valid_r       <= 1'b0;
              sop_r         <= 1'b0;
              eop_r         <= 1'b0;
              gap_cnt_r     <= '0;
              frame_count_r <= frame_count_r + 16'd1;
            end else begin
              sop_r     <= 1'b0;
              eop_r     <= nxt_last_s;
              pattern_r <= pattern_nxt_s;
              bar_idx_r <= nb_idx_s;
              bar_cnt_r <= nb_cnt_s;
            end
          end else begin
            valid_r <= valid_r;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_W'(GAP_LAST)) begin
            if (enable) begin
              state_r <= PREFETCH;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          sop_r   <= 1'b0;
          eop_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // ROM data bypasses the pattern register so both paths share one latency.
  assign st.data          = valid_r ? ((mode_r == MODE_ROM) ? rom_data : pattern_r) : '0;
  assign st.startofpacket = sop_r;
  assign st.endofpacket   = eop_r;
  assign st.valid         = valid_r;
  assign frame_count      = frame_count_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_pattern_frame_source.sv
module tb_pattern_frame_source;
  import pattern_pkg::*;

  localparam int WIDTH = 8, HEIGHT = 4, PIX_W = 12, GAP_CYCLES = 2;
  localparam int CHECK_SHIFT = 1, GRAD_SHIFT = 0, ADDR_W = 5, NPIX = 32;

  typedef struct {
    logic [1:0]  mode;
    logic        rnd_ready;
    logic [11:0] exp_data;
    logic        exp_sop;
    logic        exp_eop;
    logic        chk_addr;
    logic [4:0]  exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic reset, enable, ready;
  logic [1:0] mode;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0] rom_data = '0;
  logic [15:0] frame_count;
  logic busy;

  int tests = 0;
  int fails = 0;

  vec_t tbl [0:127];
  logic [11:0] bars [0:7];
  logic [11:0] chk_line [0:7];
  logic [11:0] cap_data [0:NPIX-1];
  logic        cap_sop  [0:NPIX-1];
  logic        cap_eop  [0:NPIX-1];
  logic [4:0]  cap_addr [0:NPIX-1];

  pattern_frame_source_if #(.PIX_W(PIX_W)) st_if ();
  assign st_if.ready = ready;

  pattern_frame_source #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W), .GAP_CYCLES(GAP_CYCLES),
    .CHECK_SHIFT(CHECK_SHIFT), .GRAD_SHIFT(GRAD_SHIFT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .rom_addr(rom_addr), .rom_data(rom_data), .st(st_if),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM model: each word holds its own address.
  always @(posedge clk) rom_data <= {7'b0, rom_addr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic rnd, input int n_beats, input int sw_beat,
                           input logic [1:0] sw_mode, input int drop_beat);
    int got = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [13:0] hv = '0;
    while (got < n_beats && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (got == sw_beat) mode = sw_mode;
      if (got == drop_beat) enable = 1'b0;
      if (held)
        check($sformatf("hold_b%0d", got),
              {17'b0, st_if.valid, st_if.data, st_if.startofpacket, st_if.endofpacket},
              {17'b0, 1'b1, hv});
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (st_if.valid && ready) begin
        cap_data[got] = st_if.data;
        cap_sop[got]  = st_if.startofpacket;
        cap_eop[got]  = st_if.endofpacket;
        cap_addr[got] = rom_addr;
        got++;
        held = 1'b0;
      end else if (st_if.valid) begin
        held = 1'b1;
        hv = {st_if.data, st_if.startofpacket, st_if.endofpacket};
      end else begin
        held = 1'b0;
      end
    end
    ready = 1'b1;
    check("frame_beats", 32'(got), 32'(n_beats));
  endtask

  task automatic compare_frame(input int g);
    for (int b = 0; b < NPIX; b++) begin
      check($sformatf("g%0d_pix%0d", g, b),
            {18'b0, cap_data[b], cap_sop[b], cap_eop[b]},
            {18'b0, tbl[g*32+b].exp_data, tbl[g*32+b].exp_sop, tbl[g*32+b].exp_eop});
      if (tbl[g*32+b].chk_addr)
        check($sformatf("rom_addr_b%0d", b), 32'(cap_addr[b]), 32'(tbl[g*32+b].exp_addr));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_falls", 32'(busy), 32'd0);
  endtask

  task automatic post_frame(input int exp_fc);
    @(negedge clk);
    check("valid_after_eop0", 32'(st_if.valid), 32'd0);
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    @(negedge clk);
    check("valid_after_eop1", 32'(st_if.valid), 32'd0);
    wait_idle();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(st_if.valid), 32'd0);
    check({tag, "_sop"}, 32'(st_if.startofpacket), 32'd0);
    check({tag, "_eop"}, 32'(st_if.endofpacket), 32'd0);
    check({tag, "_data"}, 32'(st_if.data), 32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int x, y, i, vcnt;
    bars     = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    chk_line = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    // Groups: 0 bars, 1 ROM, 2 checker with random ready, 3 ramp.
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < NPIX; b++) begin
        x = b % 8;
        y = b / 8;
        i = g * 32 + b;
        tbl[i].exp_sop   = (b == 0);
        tbl[i].exp_eop   = (b == NPIX - 1);
        tbl[i].chk_addr  = (g == 1);
        tbl[i].exp_addr  = 5'((b + 1) % 32);
        tbl[i].rnd_ready = (g == 2);
        case (g)
          0: begin tbl[i].mode = 2'd1; tbl[i].exp_data = bars[x]; end
          1: begin tbl[i].mode = 2'd0; tbl[i].exp_data = 12'(b); end
          2: begin
            tbl[i].mode = 2'd3;
            // CHECK_SHIFT=1: y>>1 is 0 on lines 0,1 and 1 on lines 2,3.
            tbl[i].exp_data = chk_line[x] ^ ((y >= 2) ? 12'hFFF : 12'h000);
          end
          default: begin tbl[i].mode = 2'd2; tbl[i].exp_data = 12'(x) * 12'h111; end
        endcase
      end
    end

    reset = 1'b1; enable = 1'b0; mode = 2'd0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven frames, each started by a one-cycle enable pulse.
    for (int g = 0; g < 3; g++) begin
      mode = tbl[g*32].mode;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      run_frame(tbl[g*32].rnd_ready, NPIX, -1, 2'd0, -1);
      post_frame(g + 1);
      compare_frame(g);
    end

    // Enable dropped mid-frame: frame completes, then the source stops.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    mode = 2'd1; enable = 1'b1;
    run_frame(1'b0, NPIX, -1, 2'd0, 10);
    post_frame(1);
    compare_frame(0);
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (st_if.valid) vcnt++;
    end
    check("no_valid_after_stop", 32'(vcnt), 32'd0);

    // Mode change mid-frame only takes effect at the next frame.
    mode = 2'd1; enable = 1'b1;
    run_frame(1'b0, NPIX, 5, 2'd2, -1);
    compare_frame(0);
    run_frame(1'b0, NPIX, -1, 2'd0, -1);
    compare_frame(3);
    check("fc_before_last_eop", 32'(frame_count), 32'd2);

    // Asynchronous reset in the middle of beat 13.
    run_frame(1'b0, 13, -1, 2'd0, -1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0; mode = 2'd1; enable = 1'b1;
    run_frame(1'b0, 1, -1, 2'd0, -1);
    check("restart_pix", {19'b0, cap_data[0], cap_sop[0]}, {19'b0, 12'hFFF, 1'b1});
    check("restart_eop", 32'(cap_eop[0]), 32'd0);
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
